// File: rtl/im_loader_pkg.sv
// Shared constants and FSM state encoding for the program loader.
// IM_LOADER_CHKSUM_EN widens the state to 3 bits to make room for CHECK.
package im_loader_pkg;

  localparam logic [15:0] CODE_SEG_PC = 16'h3000;
  localparam int          WORD_BYTES  = 4;
  localparam logic [15:0] WORD_STRIDE = 16'(WORD_BYTES);

`ifdef IM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_CHECK   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/im_loader_byte_packer.sv
// Big-endian byte-to-word packer; o_word/o_word_rdy are combinational with the 4th byte.
// No internal backpressure: every i_vld cycle consumes i_byte.
module im_loader_byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_rdy
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_vld) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // Completed word is visible in the same cycle the last byte is accepted.
  assign o_word     = {r_shift, i_byte};
  assign o_word_rdy = i_vld && (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/im_loader.sv
// Program loader: packs a byte stream into words written to IM; 5 cycles/word minimum.
// byte_ready is high only while collecting; optional IM_LOADER_CHKSUM_EN adds a trailer check.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = CODE_SEG_PC,
  parameter int          LEN_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             im_we,
  output logic [15:0]      im_addr,
  output logic [31:0]      im_din,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_wcnt;
  logic [LEN_W-1:0] w_wcnt_inc;
  logic [15:0]      r_addr;
  logic [31:0]      r_din;
  logic             w_start_acc;
  logic             w_collecting;
  logic             w_accept;
  logic [31:0]      w_word;
  logic             w_word_rdy;
  logic             w_last_word;

  assign w_start_acc  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
`ifdef IM_LOADER_CHKSUM_EN
  assign w_collecting = (r_state == ST_COLLECT) || (r_state == ST_CHECK);
`else
  assign w_collecting = (r_state == ST_COLLECT);
`endif
  assign w_accept     = byte_valid && w_collecting;
  assign w_wcnt_inc   = r_wcnt + LEN_W'(1);
  assign w_last_word  = (w_wcnt_inc == r_len);

  im_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_acc),
    .i_vld      (w_accept),
    .i_byte     (byte_in),
    .o_word     (w_word),
    .o_word_rdy (w_word_rdy)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = (len == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_word_rdy) w_next = ST_WRITE;
      end
      ST_WRITE: begin
`ifdef IM_LOADER_CHKSUM_EN
        w_next = w_last_word ? ST_CHECK : ST_COLLECT;
`else
        w_next = w_last_word ? ST_DONE : ST_COLLECT;
`endif
      end
`ifdef IM_LOADER_CHKSUM_EN
      ST_CHECK: begin
        if (w_word_rdy) w_next = ST_DONE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_addr <= BASE_ADDR;
    end else if (w_start_acc) begin
      r_len  <= len;
      r_wcnt <= '0;
      r_addr <= BASE_ADDR;
    end else if (r_state == ST_WRITE) begin
      r_wcnt <= w_wcnt_inc;
      r_addr <= r_addr + WORD_STRIDE;
    end
  end

  // Trailer bytes in CHECK never reach im_din.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_din <= '0;
    else if ((r_state == ST_COLLECT) && w_word_rdy) r_din <= w_word;
  end

`ifdef IM_LOADER_CHKSUM_EN
  logic [31:0] r_chk;
  logic        r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk <= '0;
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_chk <= '0;
      r_err <= 1'b0;
    end else if (r_state == ST_WRITE) begin
      r_chk <= r_chk ^ r_din;
    end else if ((r_state == ST_CHECK) && w_word_rdy) begin
      r_err <= (w_word != r_chk);
    end
  end

  assign err  = r_err;
  assign busy = (r_state == ST_COLLECT) || (r_state == ST_WRITE) || (r_state == ST_CHECK);
`else
  assign err  = 1'b0;
  assign busy = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
`endif

  assign byte_ready = w_collecting;
  assign im_we      = (r_state == ST_WRITE);
  assign im_addr    = r_addr;
  assign im_din     = r_din;
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench: stimulus pushes expected IM writes, a negedge monitor pops and compares.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [11:0] len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready, im_we, busy, done, err;
  logic [15:0] im_addr;
  logic [31:0] im_din;
  logic        byte_ready2, im_we2, busy2, done2, err2;
  logic [15:0] im_addr2;
  logic [31:0] im_din2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_cnt = 0, we_cnt2 = 0;
  int last_we_cyc = 0, last_we_cyc2 = 0;
  int we_times[$];
  logic [47:0] exp1[$];
  logic [47:0] exp2[$];
  logic [7:0]  pat[$];
  logic [7:0]  tx_q[$];

  im_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we),
    .im_addr(im_addr), .im_din(im_din), .busy(busy), .done(done), .err(err)
  );

  im_loader #(.BASE_ADDR(16'hFFF8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .len(len), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready2), .im_we(im_we2),
    .im_addr(im_addr2), .im_din(im_din2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (im_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        we_times.push_back(cyc);
        if (exp1.size() == 0) chk("unexpected_write", {32'h0, im_addr, im_din}, 64'h0);
        else chk("write", {16'h0, im_addr, im_din}, {16'h0, exp1.pop_front()});
      end
      if (im_we2) begin
        we_cnt2++;
        last_we_cyc2 = cyc;
        if (exp2.size() == 0) chk("unexpected_write2", {32'h0, im_addr2, im_din2}, 64'h0);
        else chk("write2", {16'h0, im_addr2, im_din2}, {16'h0, exp2.pop_front()});
      end
    end
  end

  // Reference: word w lands at base+4w, bytes 4w..4w+3 big-endian.
  task automatic model(input int sel, input logic [15:0] base, input int n);
    logic [15:0] a;
    logic [31:0] d;
    for (int w = 0; w < n; w++) begin
      a = base + 16'(4 * w);
      d = {pat[4*w], pat[4*w+1], pat[4*w+2], pat[4*w+3]};
      if (sel == 0) exp1.push_back({a, d});
      else          exp2.push_back({a, d});
    end
  endtask

  task automatic fill_pat(input int nbytes, input bit ramp);
    pat.delete();
    for (int i = 0; i < nbytes; i++) pat.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
  endtask

  task automatic start_load(input int sel, input int n);
    len = 12'(n);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  // mode 0: always valid, 1: toggle each cycle, 2: random
  task automatic stream(input int mode);
    int  guard = 0;
    bit  acc;
    while (tx_q.size() > 0 && guard < 2000) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = cyc[0];
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_in = byte_valid ? tx_q[0] : 8'hXX;
      @(negedge clk);
      acc = byte_valid && (byte_ready || byte_ready2);
      @(posedge clk); #1;
      if (acc) void'(tx_q.pop_front());
      guard++;
    end
    byte_valid = 1'b0;
    byte_in = 8'h00;
    if (tx_q.size() != 0) chk("stream_timeout", 64'(tx_q.size()), 64'h0);
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    bit d = 1'b0;
    while (!d && n < 300) begin
      @(negedge clk);
      d = (sel == 0) ? done : done2;
      n++;
    end
    chk("done_reached", {63'h0, d}, 64'h1);
    if (d) chk("done_lat", 64'(cyc - ((sel == 0) ? last_we_cyc : last_we_cyc2)), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base_cnt;
    int bad;
    int n;
    rst = 1'b0; start = 1'b0; start2 = 1'b0; len = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'h0, byte_ready}, 64'h0);
    chk("rst_we",    {63'h0, im_we},      64'h0);
    chk("rst_addr",  64'(im_addr),        64'h3000);
    chk("rst_din",   64'(im_din),         64'h0);
    chk("rst_flags", {61'h0, busy, done, err}, 64'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // len=0 from IDLE: done next cycle, no bytes taken, no writes
    byte_valid = 1'b1; byte_in = 8'hAA;
    start_load(0, 0);
    chk("len0_done", {63'h0, done}, 64'h1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (byte_ready || busy || !done) bad++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("len0_idle", 64'(bad), 64'h0);
    chk("len0_nowe", 64'(we_cnt), 64'h0);

    // ramp 00..27, back-to-back
    fill_pat(40, 1'b1);
    model(0, 16'h3000, 10);
    tx_q = pat;
    we_times.delete();
    start_load(0, 10);
    chk("busy_flags", {62'h0, busy, done}, 64'h2);
    stream(0);
    wait_done(0);
    chk("ramp_we_cnt", 64'(we_cnt), 64'd10);
    bad = 0;
    for (int i = 1; i < we_times.size(); i++) if (we_times[i] - we_times[i-1] != 5) bad++;
    chk("ramp_spacing", 64'(bad), 64'h0);
    chk("hold_addr", 64'(im_addr), 64'h3028);
    chk("hold_din",  64'(im_din),  64'h24252627);
    chk("ramp_drained", 64'(exp1.size()), 64'h0);

    // same stream, valid toggling
    model(0, 16'h3000, 10);
    tx_q = pat;
    start_load(0, 10);
    stream(1);
    wait_done(0);
    chk("toggle_we_cnt", 64'(we_cnt), 64'd20);

    // start mid-load must be ignored
    fill_pat(16, 1'b0);
    model(0, 16'h3000, 4);
    tx_q = pat[0:5];
    start_load(0, 4);
    stream(0);
    len = 12'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tx_q = pat[6:15];
    stream(2);
    wait_done(0);
    chk("midstart_drained", 64'(exp1.size()), 64'h0);

    // random loads
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      fill_pat(4 * n, 1'b0);
      model(0, 16'h3000, n);
      tx_q = pat;
      start_load(0, n);
      stream(2);
      wait_done(0);
      chk("rand_drained", 64'(exp1.size()), 64'h0);
    end

    // reset after 2 bytes of the third word
    fill_pat(20, 1'b0);
    model(0, 16'h3000, 2);
    base_cnt = we_cnt;
    tx_q = pat[0:9];
    start_load(0, 5);
    stream(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_writes", 64'(we_cnt - base_cnt), 64'd2);
    chk("mid_rst_addr", 64'(im_addr), 64'h3000);
    chk("mid_rst_din",  64'(im_din),  64'h0);
    chk("mid_rst_flags", {60'h0, byte_ready, busy, done, im_we}, 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    fill_pat(4, 1'b0);
    model(0, 16'h3000, 1);
    tx_q = pat;
    start_load(0, 1);
    stream(0);
    wait_done(0);
    chk("reload_drained", 64'(exp1.size()), 64'h0);

    // address wrap on the FFF8-based instance
    fill_pat(12, 1'b0);
    model(1, 16'hFFF8, 3);
    chk("wrap_model_last", 64'(exp2[2][47:32]), 64'h0000);
    tx_q = pat;
    start_load(1, 3);
    stream(0);
    wait_done(1);
    chk("wrap_we_cnt", 64'(we_cnt2), 64'd3);
    chk("wrap_addr_hold", 64'(im_addr2), 64'h0004);
    chk("err_low", {62'h0, err, err2}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
